// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine with HI/LO registers for the
// EX stage. Multiply is 1-bit-per-cycle shift-add and divide is restoring.
// Both operate on operand magnitudes, with sign correction applied in FINISH.
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   When defined, a multiply ends early once the remaining multiplier bits
//   are all zero. The product is shifted into place in a single step.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   start, op          issue request (sampled in IDLE); 00 mult, 01 multu,
//                      10 div, 11 divu
//   rs_data, rt_data   multiplicand/dividend, multiplier/divisor
//   flush              abort in-flight operation; suppresses start in IDLE
//   hilo_read          mfhi/mflo in EX this cycle
//   we_hi, we_lo       mthi/mtlo write enables
//   wdata              mthi/mtlo data
//   busy               operation in flight
//   done               one-cycle pulse when HI/LO are updated
//   div_by_zero        one-cycle pulse with done when the divisor was zero
//   stall              combinational pipeline hold
//   hi, lo             HI/LO registers
module muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  input  logic              hilo_read,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t              state;
  logic                div_q;     // latched op: 1 = divide
  logic                neg_res;   // product/quotient needs negation
  logic                neg_rem;   // remainder takes the dividend's sign
  logic                dbz_q;
  logic [DATA_W-1:0]   opb;       // multiplicand (mult) or divisor (div)
  logic [2*DATA_W-1:0] acc;       // product, or remainder:quotient
  logic [CNT_W-1:0]    cnt;
`ifdef MULDIV_EARLY_OUT_EN
  logic [DATA_W-1:0]   mq;        // multiplier bits not yet consumed
  logic [CNT_W-1:0]    shamt;
`endif

  logic                rs_neg, rt_neg;
  logic [DATA_W-1:0]   rs_mag, rt_mag;
  logic [DATA_W:0]     mul_sum, rem_sh, diff;
  logic [2*DATA_W-1:0] mul_next, div_next, prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix;

  assign stall = busy & (hilo_read | start | we_hi | we_lo);

  always_comb begin
    rs_neg = ~op[0] & rs_data[DATA_W-1];
    rt_neg = ~op[0] & rt_data[DATA_W-1];
    rs_mag = rs_neg ? -rs_data : rs_data;
    rt_mag = rt_neg ? -rt_data : rt_data;

    // Shift-add: the carry out of the upper-half add shifts into the MSB.
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opb};
    mul_next = acc[0] ? {mul_sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};

    // Restoring divide: the shifted remainder needs DATA_W+1 bits before
    // the trial subtract, because it can reach 2*divisor-1.
    rem_sh   = acc[2*DATA_W-1:DATA_W-1];
    diff     = rem_sh - {1'b0, opb};
    div_next = diff[DATA_W] ? {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                            : {diff[DATA_W-1:0],   acc[DATA_W-2:0], 1'b1};

    prod_fix = neg_res ? -acc : acc;
    quot_fix = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    rem_fix  = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
`ifdef MULDIV_EARLY_OUT_EN
    shamt    = CNT_W'(DATA_W) - cnt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_q       <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dbz_q       <= 1'b0;
      opb         <= '0;
      acc         <= '0;
      cnt         <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      mq          <= '0;
`endif
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (we_hi) hi <= wdata;
          if (we_lo) lo <= wdata;
          if (start && !flush) begin
            div_q   <= op[1];
            neg_res <= rs_neg ^ rt_neg;
            neg_rem <= rs_neg;
            cnt     <= '0;
            busy    <= 1'b1;
            if (op[1]) begin
              opb <= rt_mag;
              acc <= {{DATA_W{1'b0}}, rs_mag};
            end else begin
              opb <= rs_mag;
              acc <= {{DATA_W{1'b0}}, rt_mag};
            end
`ifdef MULDIV_EARLY_OUT_EN
            mq <= rt_mag;
`endif
            if (op[1] && rt_data == '0) begin
              dbz_q <= 1'b1;
              state <= FINISH;
            end else begin
              dbz_q <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            if (!div_q && mq == '0) begin
              // All remaining iterations would only shift: apply them at once.
              acc   <= acc >> shamt;
              state <= FINISH;
            end else begin
              mq  <= mq >> 1;
              acc <= div_q ? div_next : mul_next;
              if (cnt == CNT_W'(DATA_W - 1)) state <= FINISH;
            end
`else
            acc <= div_q ? div_next : mul_next;
            if (cnt == CNT_W'(DATA_W - 1)) state <= FINISH;
`endif
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            done        <= 1'b1;
            div_by_zero <= dbz_q;
            if (!dbz_q) begin
              if (div_q) begin
                hi <= rem_fix;
                lo <= quot_fix;
              end else begin
                hi <= prod_fix[2*DATA_W-1:DATA_W];
                lo <= prod_fix[DATA_W-1:0];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
